// File: rtl/tiger_fetch.sv
// tiger_fetch: instruction fetch stage of the tiger MIPS pipeline.
// Holds the PC, issues single-outstanding Avalon-style reads, and presents
// the fetched word plus its PC to decode. A NOP (32'h0) is driven whenever
// no valid instruction is held.
// Optional feature: define FETCH_STALL_COUNT_EN to build a saturating
// counter of cycles in which decode receives no valid instruction.
module tiger_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0080_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flushPc,
  input  logic [31:0] nextpc,
  output logic [31:0] iaddress,
  output logic        iread,
  input  logic        iwaitrequest,
  input  logic [31:0] ireaddata,
  input  logic        ireaddatavalid,
  output logic [31:0] instrDe,
  output logic [31:0] pcDe,
  output logic        instrValidDe,
  output logic [31:0] fetchStallCount
);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    DROP  = 2'd3
  } fetchState_t;

  fetchState_t state;
  fetchState_t stateNext;

  logic [31:0] pc;
  logic [31:0] pcNext;
  logic [31:0] instrReg;
  logic [31:0] instrRegNext;
  logic [31:0] pcDeReg;
  logic [31:0] pcDeNext;
  logic        dropPending;
  logic        dropPendingNext;
  logic [31:0] pendPc;
  logic [31:0] pendPcNext;

  logic        accept;
  logic [29:0] addrWord;

  // State and datapath registers; reset has priority over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= REQ;
      pc          <= RESET_VECTOR;
      instrReg    <= 32'h0;
      pcDeReg     <= 32'h0;
      dropPending <= 1'b0;
      pendPc      <= 32'h0;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      instrReg    <= instrRegNext;
      pcDeReg     <= pcDeNext;
      dropPending <= dropPendingNext;
      pendPc      <= pendPcNext;
    end
  end

  // Next-state and memory-request logic; flush outranks accept and stall.
  always_comb begin
    stateNext       = state;
    pcNext          = pc;
    instrRegNext    = instrReg;
    pcDeNext        = pcDeReg;
    dropPendingNext = dropPending;
    pendPcNext      = pendPc;
    accept          = 1'b0;
    iread           = 1'b0;
    addrWord        = pc[31:2];

    case (state)
      REQ: begin
        iread = 1'b1;
        if (flush) begin
          pendPcNext = flushPc;
          if (iwaitrequest) begin
            dropPendingNext = 1'b1;
          end else begin
            stateNext = DROP;
          end
        end else if (!iwaitrequest) begin
          stateNext = dropPending ? DROP : WAIT;
        end
      end

      WAIT: begin
        if (flush) begin
          if (ireaddatavalid) begin
            pcNext    = flushPc;
            stateNext = REQ;
          end else begin
            pendPcNext = flushPc;
            stateNext  = DROP;
          end
        end else if (ireaddatavalid) begin
          instrRegNext = ireaddata;
          pcDeNext     = pc;
          stateNext    = VALID;
        end
      end

      VALID: begin
        if (flush) begin
          pcNext    = flushPc;
          stateNext = REQ;
        end else if (!stall) begin
          accept    = 1'b1;
          iread     = 1'b1;
          addrWord  = nextpc[31:2];
          pcNext    = nextpc;
          stateNext = iwaitrequest ? REQ : WAIT;
        end
      end

      DROP: begin
        if (ireaddatavalid) begin
          pcNext          = flush ? flushPc : pendPc;
          dropPendingNext = 1'b0;
          stateNext       = REQ;
        end else if (flush) begin
          pendPcNext = flushPc;
        end
      end

      default: begin
        stateNext = REQ;
      end
    endcase
  end

  // Decode-facing outputs: a NOP whenever no valid instruction is held.
  always_comb begin
    instrValidDe = (state == VALID);
    instrDe      = (state == VALID) ? instrReg : 32'h0;
    pcDe         = pcDeReg;
    iaddress     = {addrWord, 2'b00};
  end

`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stallCount;

  // Count cycles where decode sees no valid instruction, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCount <= 32'h0;
    end else if (!instrValidDe && (stallCount != 32'hFFFF_FFFF)) begin
      stallCount <= stallCount + 32'd1;
    end
  end

  assign fetchStallCount = stallCount;
`else
  assign fetchStallCount = 32'h0;
`endif

endmodule

// File: tb/tb_tiger_fetch.sv
// tb_tiger_fetch: table-driven directed bench for tiger_fetch.
// Each table row holds one cycle of inputs and the outputs expected in it.
module tb_tiger_fetch;

  localparam logic [31:0] RV   = 32'h0080_0000;
  localparam logic [31:0] JUNK = 32'hDEAD_BEE0;
`ifdef FETCH_STALL_COUNT_EN
  localparam logic [31:0] EXP_COUNT = 32'd7;
`else
  localparam logic [31:0] EXP_COUNT = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] flushPc;
  logic [31:0] nextpc;
  logic [31:0] iaddress;
  logic        iread;
  logic        iwaitrequest;
  logic [31:0] ireaddata;
  logic        ireaddatavalid;
  logic [31:0] instrDe;
  logic [31:0] pcDe;
  logic        instrValidDe;
  logic [31:0] fetchStallCount;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic [31:0] flushPc;
    logic [31:0] nextpc;
    logic        iwaitrequest;
    logic        ireaddatavalid;
    logic [31:0] ireaddata;
    logic        expIread;
    logic [31:0] expIaddress;
    logic        expValid;
    logic [31:0] expInstr;
    logic [31:0] expPcDe;
  } vec_t;

  vec_t vecs[$];

  tiger_fetch #(.RESET_VECTOR(RV)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .flushPc         (flushPc),
    .nextpc          (nextpc),
    .iaddress        (iaddress),
    .iread           (iread),
    .iwaitrequest    (iwaitrequest),
    .ireaddata       (ireaddata),
    .ireaddatavalid  (ireaddatavalid),
    .instrDe         (instrDe),
    .pcDe            (pcDe),
    .instrValidDe    (instrValidDe),
    .fetchStallCount (fetchStallCount)
  );

  // Free-running clock, posedge at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic s, input logic f, input logic [31:0] fpc, input logic [31:0] npc,
    input logic w, input logic rdv, input logic [31:0] rd,
    input logic eRd, input logic [31:0] eAddr, input logic eV,
    input logic [31:0] eI, input logic [31:0] eP);
    vec_t v;
    v.stall = s;          v.flush = f;           v.flushPc = fpc;
    v.nextpc = npc;       v.iwaitrequest = w;    v.ireaddatavalid = rdv;
    v.ireaddata = rd;     v.expIread = eRd;      v.expIaddress = eAddr;
    v.expValid = eV;      v.expInstr = eI;       v.expPcDe = eP;
    return v;
  endfunction

  task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset          = 1'b0;
    stall          = v.stall;
    flush          = v.flush;
    flushPc        = v.flushPc;
    nextpc         = v.nextpc;
    iwaitrequest   = v.iwaitrequest;
    ireaddatavalid = v.ireaddatavalid;
    ireaddata      = v.ireaddata;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    checkWord({tag, ".iread"}, {31'b0, iread}, {31'b0, v.expIread});
    if (v.expIread) checkWord({tag, ".iaddress"}, iaddress, v.expIaddress);
    checkWord({tag, ".instrValidDe"}, {31'b0, instrValidDe}, {31'b0, v.expValid});
    checkWord({tag, ".instrDe"}, instrDe, v.expInstr);
    checkWord({tag, ".pcDe"}, pcDe, v.expPcDe);
  endtask

  task automatic runVector(input vec_t v, input string tag);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput(v, tag);
  endtask

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Fields: stall flush flushPc nextpc iwait rdvalid rdata | iread iaddr valid instr pcDe
    vecs.push_back(mk(0,0,0,JUNK,0,0,0,                      1,RV,0,0,0));
    vecs.push_back(mk(0,0,0,JUNK,0,1,32'h2408_0005,          0,0,0,0,0));
    vecs.push_back(mk(1,0,0,32'h0080_0004,0,0,0,             0,0,1,32'h2408_0005,RV));
    vecs.push_back(mk(1,0,0,32'h0080_0004,0,0,0,             0,0,1,32'h2408_0005,RV));
    vecs.push_back(mk(1,0,0,32'h0080_0004,0,0,0,             0,0,1,32'h2408_0005,RV));
    vecs.push_back(mk(0,0,0,32'h0080_0004,0,0,0,             1,32'h0080_0004,1,32'h2408_0005,RV));
    vecs.push_back(mk(0,0,0,JUNK,0,1,32'h8C09_0010,          0,0,0,0,RV));
    vecs.push_back(mk(0,0,0,32'h0080_0008,1,0,0,             1,32'h0080_0008,1,32'h8C09_0010,32'h0080_0004));
    vecs.push_back(mk(0,0,0,JUNK,1,0,0,                      1,32'h0080_0008,0,0,32'h0080_0004));
    vecs.push_back(mk(0,0,0,32'h0080_1000,1,0,0,             1,32'h0080_0008,0,0,32'h0080_0004));
    vecs.push_back(mk(0,0,0,JUNK,1,1,32'hCAFE_F00D,          1,32'h0080_0008,0,0,32'h0080_0004));
    vecs.push_back(mk(0,0,0,JUNK,1,0,0,                      1,32'h0080_0008,0,0,32'h0080_0004));
    vecs.push_back(mk(0,0,0,JUNK,0,0,0,                      1,32'h0080_0008,0,0,32'h0080_0004));
    vecs.push_back(mk(0,0,0,JUNK,0,0,0,                      0,0,0,0,32'h0080_0004));
    vecs.push_back(mk(0,0,0,JUNK,0,1,32'hAC0A_0020,          0,0,0,0,32'h0080_0004));
    vecs.push_back(mk(1,1,32'h0080_0100,32'h0080_000C,0,0,0, 0,0,1,32'hAC0A_0020,32'h0080_0008));
    vecs.push_back(mk(0,0,0,JUNK,0,0,0,                      1,32'h0080_0100,0,0,32'h0080_0008));
    vecs.push_back(mk(0,1,32'h0080_0180,JUNK,0,0,0,          0,0,0,0,32'h0080_0008));
    vecs.push_back(mk(0,0,0,JUNK,0,1,32'hFFFF_FFFF,          0,0,0,0,32'h0080_0008));
    vecs.push_back(mk(0,0,0,JUNK,0,0,0,                      1,32'h0080_0180,0,0,32'h0080_0008));
    vecs.push_back(mk(0,0,0,JUNK,0,1,32'h0109_5020,          0,0,0,0,32'h0080_0008));
    vecs.push_back(mk(0,0,0,32'h0080_0184,0,0,0,             1,32'h0080_0184,1,32'h0109_5020,32'h0080_0180));
    vecs.push_back(mk(0,0,0,JUNK,0,1,32'h3C01_1234,          0,0,0,0,32'h0080_0180));
    vecs.push_back(mk(0,1,32'h0080_0200,32'h0080_0188,0,0,0, 0,0,1,32'h3C01_1234,32'h0080_0184));
    vecs.push_back(mk(0,1,32'h0080_0300,JUNK,1,0,0,          1,32'h0080_0200,0,0,32'h0080_0184));
    vecs.push_back(mk(0,0,0,JUNK,0,0,0,                      1,32'h0080_0200,0,0,32'h0080_0184));
    vecs.push_back(mk(0,1,32'h0080_0400,JUNK,0,0,0,          0,0,0,0,32'h0080_0184));
    vecs.push_back(mk(0,0,0,JUNK,0,1,32'hDEAD_DEAD,          0,0,0,0,32'h0080_0184));
    vecs.push_back(mk(0,0,0,JUNK,0,0,0,                      1,32'h0080_0400,0,0,32'h0080_0184));
    vecs.push_back(mk(0,0,0,JUNK,0,1,32'h1234_5678,          0,0,0,0,32'h0080_0184));
    vecs.push_back(mk(1,0,0,JUNK,0,0,0,                      0,0,1,32'h1234_5678,32'h0080_0400));

    reset = 1'b1; stall = 1'b0; flush = 1'b0; flushPc = 32'h0; nextpc = 32'h0;
    iwaitrequest = 1'b0; ireaddatavalid = 1'b0; ireaddata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkWord("reset.iread", {31'b0, iread}, 32'd1);
    checkWord("reset.iaddress", iaddress, RV);
    checkWord("reset.instrValidDe", {31'b0, instrValidDe}, 32'd0);
    checkWord("reset.instrDe", instrDe, 32'h0);
    checkWord("reset.pcDe", pcDe, 32'h0);
    checkWord("reset.fetchStallCount", fetchStallCount, 32'h0);

    $display("[TB] applying %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      runVector(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset from VALID with flush and stall asserted: reset must win.
    @(negedge clk);
    reset = 1'b1; stall = 1'b1; flush = 1'b1; flushPc = 32'h0090_0000;
    iwaitrequest = 1'b1; ireaddatavalid = 1'b1; ireaddata = 32'h1111_1111;
    @(negedge clk);
    #1;
    checkWord("rst2.iread", {31'b0, iread}, 32'd1);
    checkWord("rst2.iaddress", iaddress, RV);
    checkWord("rst2.instrValidDe", {31'b0, instrValidDe}, 32'd0);
    checkWord("rst2.instrDe", instrDe, 32'h0);
    checkWord("rst2.pcDe", pcDe, 32'h0);
    checkWord("rst2.fetchStallCount", fetchStallCount, 32'h0);

    // Five waitrequest cycles, then accept, then one WAIT cycle.
    for (int i = 0; i < 5; i++) begin
      runVector(mk(0,0,0,JUNK,1,0,0, 1,RV,0,0,0), $sformatf("hold%0d", i));
    end
    runVector(mk(0,0,0,JUNK,0,0,0, 1,RV,0,0,0), "holdAccept");
    runVector(mk(0,0,0,JUNK,0,1,32'h2408_0005, 0,0,0,0,0), "holdWait");
    runVector(mk(1,0,0,JUNK,0,0,0, 0,0,1,32'h2408_0005,RV), "holdValid");
    checkWord("holdValid.fetchStallCount", fetchStallCount, EXP_COUNT);
    runVector(mk(1,0,0,JUNK,0,0,0, 0,0,1,32'h2408_0005,RV), "holdValid2");
    checkWord("holdValid2.fetchStallCount", fetchStallCount, EXP_COUNT);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
